// File: rtl/ped_request_ctrl.sv
// Pedestrian button conditioner: synchronize, debounce, edge-detect and latch
// a crossing request, with a hold-off window after each service.
module ped_request_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned HOLDOFF_CYC  = 8,
  parameter int unsigned CNT_W        = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_btn_raw,
  input  logic             i_ack,
  output logic             o_req,
  output logic             o_btn_clean,
  output logic             o_press_pulse,
  output logic             o_holdoff,
  output logic [CNT_W-1:0] o_press_count
);

  localparam int unsigned DB_W = 4;
  localparam int unsigned HO_W = 8;
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HO_W-1:0]  HO_LOAD = HO_W'(HOLDOFF_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PENDING = 3'd1,
    ST_SERVING = 3'd2,
    ST_HOLDOFF = 3'd3
  } state_t;

  logic            r_s1;
  logic            r_s2;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_btn_clean;
  logic            r_btn_clean_d;
  logic            r_press_pulse;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [HO_W-1:0] r_timer;
  logic [HO_W-1:0] w_timer_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic            r_req;
  logic            r_holdoff;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_btn_raw;
      r_s2 <= r_s1;
    end
  end

  // Debounce: level must disagree for DEBOUNCE_CYC consecutive cycles to flip.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_db_cnt    <= '0;
      r_btn_clean <= 1'b0;
    end else if (r_s2 == r_btn_clean) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_LAST) begin
      r_btn_clean <= ~r_btn_clean;
      r_db_cnt    <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + DB_W'(1);
    end
  end

  // Rising-edge detect on the clean level; releases produce no pulse.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_btn_clean_d <= 1'b0;
      r_press_pulse <= 1'b0;
    end else begin
      r_btn_clean_d <= r_btn_clean;
      r_press_pulse <= r_btn_clean & ~r_btn_clean_d;
    end
  end

  // Request FSM state register; req/holdoff registered from the next state.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_count   <= '0;
      r_req     <= 1'b0;
      r_holdoff <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_count   <= w_count_nxt;
      r_req     <= (w_state_nxt == ST_PENDING);
      r_holdoff <= (w_state_nxt == ST_HOLDOFF);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_count_nxt = r_count;
    case (r_state)
      ST_IDLE: begin
        if (r_press_pulse) begin
          w_state_nxt = ST_PENDING;
          if (r_count != CNT_MAX) begin
            w_count_nxt = r_count + CNT_W'(1);
          end
        end
      end
      ST_PENDING: begin
        if (i_ack) begin
          w_state_nxt = ST_SERVING;
        end
      end
      ST_SERVING: begin
        if (!i_ack) begin
          w_state_nxt = ST_HOLDOFF;
          w_timer_nxt = HO_LOAD;
        end
      end
      ST_HOLDOFF: begin
        if (r_timer == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_timer_nxt = r_timer - HO_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = '0;
      end
    endcase
  end

  assign o_req         = r_req;
  assign o_btn_clean   = r_btn_clean;
  assign o_press_pulse = r_press_pulse;
  assign o_holdoff     = r_holdoff;
  assign o_press_count = r_count;

endmodule
